run_pattern_gen: RTL and testbench

//  Serial stimulus transmitter for the run-length detector (INTG-class) path.
//  On start, it drives a single-bit stream X. The stream is one lead-in 0,

---
 rtl/run_pattern_gen_pkg.sv | 14 +
 rtl/run_counter.sv | 28 ++
 rtl/run_pattern_gen.sv | 96 +++++++++
 tb/tb_run_pattern_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/run_pattern_gen_pkg.sv
// Shared state encodings and default width for the run-pattern transmitter.
// The optional back-to-back repeat mode is enabled with the REPEAT_EN macro.
package run_pattern_gen_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

endpackage

// File: rtl/run_counter.sv
// W-bit run counter with synchronous clear, enable and a terminal compare
// against the latched run length.
module run_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         srst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] len_q,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge CLK) begin
    if (srst || clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign term = (cnt_reg == len_q);

endmodule

// File: rtl/run_pattern_gen.sv
// Serial burst transmitter: one lead-in 0, LEN+1 ones, one trailing 0 with DONE.
// Define REPEAT_EN to let a held start chain bursts directly from TAIL into LEAD.
module run_pattern_gen
  import run_pattern_gen_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         CLK,
  input  logic         CLEAR,
  input  logic         S,
  input  logic         ABORT,
  input  logic [W-1:0] LEN,
  output logic         X,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] cnt_out
);

  state_t       state_reg, state_next;
  logic [W-1:0] len_reg, len_next;
  logic         cnt_clr;
  logic         cnt_en;
  logic         cnt_term;
  logic [W-1:0] cnt_val;

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // ABORT outranks a simultaneous start request.
        if (S && !ABORT) begin
          state_next = ST_LEAD;
          len_next   = LEN;
          cnt_clr    = 1'b1;
        end
      end
      ST_LEAD: begin
        state_next = ABORT ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (ABORT) begin
          state_next = ST_IDLE;
          cnt_clr    = 1'b1;
        end else if (cnt_term) begin
          state_next = ST_TAIL;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_TAIL: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
`ifdef REPEAT_EN
        if (S && !ABORT) begin
          state_next = ST_LEAD;
          len_next   = LEN;
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  run_counter #(.W(W)) u_run_counter (
    .CLK   (CLK),
    .srst  (CLEAR),
    .clear (cnt_clr),
    .en    (cnt_en),
    .len_q (len_reg),
    .cnt   (cnt_val),
    .term  (cnt_term)
  );

  // Moore decode: outputs depend only on registered state and count.
  assign X       = (state_reg == ST_RUN);
  assign BUSY    = (state_reg != ST_IDLE);
  assign DONE    = (state_reg == ST_TAIL);
  assign cnt_out = cnt_val;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Scoreboard bench for run_pattern_gen: a cycle model pushes expected outputs
// per driven cycle, which are popped and compared after each clock edge.
module tb_run_pattern_gen;

  logic       CLK = 1'b0;
  logic       CLEAR = 1'b1;
  logic       S = 1'b0;
  logic       ABORT = 1'b0;
  logic [3:0] LEN = 4'd0;
  logic       X, BUSY, DONE;
  logic [3:0] cnt_out;

  typedef struct packed {
    logic       x;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   m_st  = 0;
  int   m_cnt = 0;
  int   m_len = 0;

  int   ones, dones, busy_low, done_at, n;

  run_pattern_gen #(.W(4)) dut (
    .CLK     (CLK),
    .CLEAR   (CLEAR),
    .S       (S),
    .ABORT   (ABORT),
    .LEN     (LEN),
    .X       (X),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .cnt_out (cnt_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit s, input bit ab, input bit clr, input logic [3:0] len);
    exp_t e;
    S = s; ABORT = ab; CLEAR = clr; LEN = len;
    if (clr) begin
      m_st = 0; m_cnt = 0; m_len = 0;
    end else begin
      case (m_st)
        0: if (s && !ab) begin m_st = 1; m_len = len; m_cnt = 0; end
        1: m_st = ab ? 0 : 2;
        2: begin
          if (ab) begin m_st = 0; m_cnt = 0; end
          else if (m_cnt == m_len) m_st = 3;
          else m_cnt = m_cnt + 1;
        end
        default: begin
          m_st = 0; m_cnt = 0;
`ifdef REPEAT_EN
          if (s && !ab) begin m_st = 1; m_len = len; end
`endif
        end
      endcase
    end
    exp_q.push_back('{x: (m_st == 2), busy: (m_st != 0), done: (m_st == 3), cnt: 4'(m_cnt)});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    n++;
    check("X", int'(X), int'(e.x));
    check("BUSY", int'(BUSY), int'(e.busy));
    check("DONE", int'(DONE), int'(e.done));
    check("cnt_out", int'(cnt_out), int'(e.cnt));
    $display("cyc %0d: S=%0b AB=%0b CLR=%0b LEN=%0d -> X=%0b BUSY=%0b DONE=%0b cnt=%0d",
             n, s, ab, clr, len, X, BUSY, DONE, cnt_out);
    if (X) ones++;
    if (DONE) begin
      dones++;
      if (done_at == 0) done_at = n;
    end
    if (!BUSY) busy_low++;
  endtask

  task automatic reset_stats();
    ones = 0; dones = 0; busy_low = 0; done_at = 0; n = 0;
  endtask

  initial begin
    // 1: reset then idle
    reset_stats();
    step(1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    reset_stats();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    check("idle_ones", ones, 0);
    check("idle_busy_low", busy_low, 10);

    // ABORT together with S in IDLE: start rejected
    reset_stats();
    step(1'b1, 1'b1, 1'b0, 4'd5);
    check("abort_start_busy_low", busy_low, 1);

    // 2: maximum length burst
    reset_stats();
    step(1'b1, 1'b0, 1'b0, 4'hF);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    check("max_ones", ones, 16);
    check("max_done_at", done_at, 18);
    check("max_dones", dones, 1);

    // 3: single-one burst
    reset_stats();
    step(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 4'd9);
    check("len0_ones", ones, 1);
    check("len0_done_at", done_at, 3);

    // 4: abort in third RUN cycle
    reset_stats();
    step(1'b1, 1'b0, 1'b0, 4'd7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd7);
    step(1'b0, 1'b1, 1'b0, 4'd7);
    check("abort_idle_busy", int'(BUSY), 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 4'd7);
    check("abort_dones", dones, 0);
    check("abort_ones", ones, 3);

    // 5: re-pulse S during RUN is ignored; LEN change has no effect
    reset_stats();
    step(1'b1, 1'b0, 1'b0, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd3);
    step(1'b1, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 4'd9);
    check("repulse_ones", ones, 4);
    check("repulse_dones", dones, 1);
    // second burst with CLEAR mid-RUN
    reset_stats();
    step(1'b1, 1'b0, 1'b0, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    check("clear_busy", int'(BUSY), 0);
    check("clear_cnt", int'(cnt_out), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 4'd3);
    check("clear_dones", dones, 0);

    // 6: S held high with LEN=2 for 15 cycles
    reset_stats();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 4'd2);
`ifdef REPEAT_EN
    check("hold_dones", dones, 3);
    check("hold_ones", ones, 9);
    check("hold_busy_low", busy_low, 0);
`else
    check("hold_dones", dones, 2);
    check("hold_ones", ones, 8);
    check("hold_busy_low", busy_low, 2);
`endif
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 4'd2);
    check("final_busy", int'(BUSY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
